// File: rtl/modexp_pkg.sv
`default_nettype none
// ============================================================================
// modexp_pkg : shared state encodings for modexp_ctrl and modmult
// Rev 1.0
// ============================================================================
package modexp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_GO   = 3'd1,
    MUL_WAIT = 3'd2,
    SQR_GO   = 3'd3,
    SQR_WAIT = 3'd4,
    FINISH   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_LOAD = 2'd1,
    MM_RUN  = 2'd2,
    MM_DONE = 2'd3
  } mm_state_t;

endpackage
`default_nettype wire

// File: rtl/modmult.sv
`default_nettype none
// ============================================================================
// modmult : result = (a * b) mod n, MSB-first interleaved over the bits of b
// Rev 1.0
// ============================================================================
module modmult
  import modexp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mm_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len;
  logic [WIDTH:0]   dbl, sum;
  logic [WIDTH-1:0] dbl_red, step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MM_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    len = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_q[i]) len = CNT_W'(i + 1);
    end
  end

  // acc and a are both < n, so each doubling/addition needs at most one subtract
  always_comb begin
    dbl     = {acc_q, 1'b0};
    dbl_red = (dbl >= {1'b0, n_q}) ? dbl[WIDTH-1:0] - n_q : dbl[WIDTH-1:0];
    sum     = {1'b0, dbl_red} + (b_q[WIDTH-1] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    step    = (sum >= {1'b0, n_q}) ? sum[WIDTH-1:0] - n_q : sum[WIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      MM_IDLE: begin
        if (go) begin
          a_d     = a % n;
          b_d     = b;
          n_d     = n;
          acc_d   = '0;
          state_d = MM_LOAD;
        end
      end
      MM_LOAD: begin
        // left-justify b so its top set bit sits in the MSB
        b_d     = b_q << (CNT_W'(WIDTH) - len);
        cnt_d   = len;
        state_d = (len == '0) ? MM_DONE : MM_RUN;
      end
      MM_RUN: begin
        acc_d = step;
        b_d   = b_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MM_DONE;
      end
      MM_DONE: state_d = MM_IDLE;
      default: state_d = MM_IDLE;
    endcase
  end

  assign result = acc_q;
  assign done   = (state_q == MM_DONE);

endmodule
`default_nettype wire

// File: rtl/modexp_ctrl.sv
`default_nettype none
// ============================================================================
// modexp_ctrl : result = base^exp mod n via right-to-left square-and-multiply
// Optional feature macro: MODEXP_EARLY_EXIT_EN (skips idle multiplies/squares)
// Rev 1.0
// ============================================================================
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, sq_q, sq_d, e_q, e_d, n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             mm_go, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_n, mm_result;

  modmult #(.WIDTH(WIDTH)) u_modmult (
    .clk    (clk),
    .rst    (rst),
    .go     (mm_go),
    .a      (mm_a),
    .b      (mm_b),
    .n      (mm_n),
    .result (mm_result),
    .done   (mm_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      sq_q    <= '0;
      e_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      sq_q    <= sq_d;
      e_q     <= e_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    sq_d    = sq_q;
    e_d     = e_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          sq_d  = base;
          e_d   = exp;
          n_d   = n;
          cnt_d = CNT_W'(WIDTH);
          res_d = (n == WIDTH'(1)) ? '0 : WIDTH'(1);
`ifdef MODEXP_EARLY_EXIT_EN
          state_d = (exp == '0) ? FINISH : MUL_GO;
`else
          state_d = MUL_GO;
`endif
        end
      end
      MUL_GO: begin
`ifdef MODEXP_EARLY_EXIT_EN
        state_d = e_q[0] ? MUL_WAIT : SQR_GO;
`else
        state_d = MUL_WAIT;
`endif
      end
      MUL_WAIT: begin
        if (mm_done) begin
          if (e_q[0]) res_d = mm_result;
`ifdef MODEXP_EARLY_EXIT_EN
          state_d = ((e_q >> 1) == '0) ? FINISH : SQR_GO;
`else
          state_d = SQR_GO;
`endif
        end
      end
      SQR_GO: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mm_done) begin
          sq_d    = mm_result;
          e_d     = e_q >> 1;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? FINISH : MUL_GO;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mm_go = 1'b0;
    mm_a  = res_q;
    mm_b  = sq_q;
    mm_n  = n_q;
    case (state_q)
`ifdef MODEXP_EARLY_EXIT_EN
      MUL_GO: mm_go = e_q[0];
`else
      MUL_GO: mm_go = 1'b1;
`endif
      SQR_GO: begin
        mm_go = 1'b1;
        mm_a  = sq_q;
      end
      default: mm_go = 1'b0;
    endcase
  end

  // result tracks the accumulator; it is final from FINISH until the next accept
  assign result = res_q;
  assign done   = (state_q == FINISH);
  assign busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_modexp_ctrl : scoreboard bench for modexp_ctrl (WIDTH=16)
// Rev 1.0
// ============================================================================
module tb_modexp_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, go;
  logic [W-1:0] base, exp_i, n_i, result;
  logic         done, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  modexp_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .base   (base),
    .exp    (exp_i),
    .n      (n_i),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // left-to-right exponentiation with wide arithmetic
  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                               input logic [W-1:0] m);
    longint unsigned r, bb, mm;
    mm = longint'(m);
    bb = longint'(b) % mm;
    r  = 1 % mm;
    for (int i = W - 1; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * bb) % mm;
    end
    return r[W-1:0];
  endfunction

  // cycles from the go cycle to the done cycle, both counted, fixed schedule:
  // each iteration costs two GO cycles plus two calls of (bitlen(square)+2)
  function automatic int ref_latency(input logic [W-1:0] b, input logic [W-1:0] m);
    longint unsigned s;
    int t;
    s = longint'(b);
    t = 1;
    for (int i = 0; i < W; i++) begin
      t += 2 * ($clog2(s + 1) + 2) + 2;
      s = (s * s) % longint'(m);
    end
    return t + 1;
  endfunction

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        check("busy_during_done", longint'(busy), 1);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done", $sformatf("done with result %0d and nothing expected", result));
        end else begin
          check("result", longint'(result), longint'(exp_q.pop_front()));
        end
        @(negedge clk);
        check("busy_after_done", longint'(busy), 0);
        check("done_single_pulse", longint'(done), 0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                          input logic [W-1:0] expv);
    @(negedge clk);
    base  = b;
    exp_i = e;
    n_i   = m;
    go    = 1'b1;
    exp_q.push_back(expv);
  endtask

  task automatic wait_done(output int lat);
    int c;
    c   = 1;
    lat = 0;
    while (1) begin
      @(negedge clk);
      go = 1'b0;
      c++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      if (c > 4000) begin
        fail_now("timeout", "no done within 4000 cycles");
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                        input logic [W-1:0] expv, output int lat);
    start_op(b, e, m, expv);
    wait_done(lat);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l2, lat;
    logic [W-1:0] rb, re, rm;

    rst   = 1'b1;
    go    = 1'b0;
    base  = '0;
    exp_i = '0;
    n_i   = '0;
    repeat (3) @(negedge clk);
    check("reset_result", longint'(result), 0);
    check("reset_done", longint'(done), 0);
    check("reset_busy", longint'(busy), 0);
    rst = 1'b0;

    run_op(16'd4, 16'd13, 16'd497, 16'd445, lat);
    run_op(16'd2, 16'd10, 16'd1000, 16'd24, lat);
    run_op(16'd3, 16'd0, 16'd7, 16'd1, lat);
`ifdef MODEXP_EARLY_EXIT_EN
    check("early_exp0_latency", lat, 2);
`endif
    run_op(16'd5, 16'd3, 16'd1, 16'd0, lat);

`ifdef MODEXP_EARLY_EXIT_EN
    // one multiply of b=9 (4 bits): GO + 6 wait cycles, then FINISH; no squaring
    run_op(16'd9, 16'd1, 16'd7, 16'd2, lat);
    check("early_no_sqr_latency", lat, 9);
`else
    run_op(16'd4, 16'h0001, 16'd497, 16'd4, l1);
    run_op(16'd4, 16'hFFFF, 16'd497, ref_modexp(16'd4, 16'hFFFF, 16'd497), l2);
    check("latency_exp_independent", l2, l1);
    check("latency_schedule", l1, ref_latency(16'd4, 16'd497));
`endif

    // stray go while busy must be ignored
    start_op(16'd4, 16'd13, 16'd497, 16'd445);
    repeat (20) begin
      @(negedge clk);
      go = 1'b0;
    end
    @(negedge clk);
    check("busy_midrun", longint'(busy), 1);
    base  = 16'd2;
    exp_i = 16'd10;
    n_i   = 16'd1000;
    go    = 1'b1;
    wait_done(lat);

    // reset in the first SQR_WAIT window (go cycle + 10)
    start_op(16'd4, 16'd13, 16'd497, 16'd445);
    repeat (10) begin
      @(negedge clk);
      go = 1'b0;
    end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_done", longint'(done), 0);
    check("midrst_busy", longint'(busy), 0);
    check("midrst_result", longint'(result), 0);
    rst = 1'b0;
    run_op(16'd4, 16'd13, 16'd497, 16'd445, lat);

    for (int i = 0; i < 10; i++) begin
      rb = W'($urandom);
      re = (i == 0) ? 16'hFFFF : W'($urandom);
      rm = W'($urandom_range(65535, 1));
      run_op(rb, re, rm, ref_modexp(rb, re, rm), lat);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modexp_ctrl.md
# modexp_ctrl

Sequencer that computes `result = base^exp mod n` by driving one `modmult` instance through right-to-left binary square-and-multiply. It sits above `modmult` in the RSA datapath and is the block the encrypt/decrypt top level calls. Without the optional macro, its operation schedule does not depend on the exponent bits.

## Interface

**Parameters**
- `WIDTH`, default 32: width of base, exponent, modulus and result.

**Ports**
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset. It is also wired to the `modmult` instance's `rst`.
- `go` input 1: start request. Sampled only in `IDLE`.
- `base` input WIDTH: base operand. Need not be reduced mod `n`.
- `exp` input WIDTH: exponent.
- `n` input WIDTH: modulus. `n = 0` gives an unspecified result.
- `result` output WIDTH: final value. Held from `done` until the next accepted `go`.
- `done` output 1: one-cycle pulse when `result` is valid.
- `busy` output 1: high from the cycle after `go` is accepted through the `done` cycle.

## Operation

**Registers**
- `res_r`: result accumulator.
- `sq_r`: running square.
- `e_r`: exponent shift register.
- `n_r`: latched modulus.
- `cnt_r`: bit counter, `$clog2(WIDTH+1)` bits.

**Accept**
- In `IDLE` with `go=1`, latch the inputs:
  - `sq_r <= base`, `e_r <= exp`, `n_r <= n`, `cnt_r <= WIDTH`.
  - `res_r <= (n == 1) ? 0 : 1`.
- Go to `MUL_GO`.

**States: `IDLE`, `MUL_GO`, `MUL_WAIT`, `SQR_GO`, `SQR_WAIT`, `FINISH`**
- `MUL_GO`: assert `mm_go` for exactly this cycle, with `mm_a = res_r`, `mm_b = sq_r`, `mm_n = n_r`. Go to `MUL_WAIT`.
- `MUL_WAIT`: on `mm_done`, load `res_r <= mm_result` only if `e_r[0] = 1`; otherwise discard it. Go to `SQR_GO`.
- `SQR_GO`: assert `mm_go`, with `mm_a = sq_r`, `mm_b = sq_r`. Go to `SQR_WAIT`.
- `SQR_WAIT`: on `mm_done`:
  - Load `sq_r <= mm_result`.
  - Update `e_r <= e_r >> 1` and `cnt_r <= cnt_r - 1`.
  - If the new `cnt_r` is 0, go to `FINISH`; otherwise go to `MUL_GO`.
- `FINISH`: `done = 1`, `result = res_r`. Go to `IDLE`.

**Rules**
- `mm_go` is asserted only in `*_GO` states. These are always entered the cycle after `mm_done` (or from `IDLE`), when `modmult` has returned to its idle state.
- `go` while `busy` is ignored. It is neither queued nor restarts the operation.
- Base reduction happens inside the first `modmult` call, because `modmult` reduces its `a` operand.
- `exp = 0` gives `result = 1 mod n` (0 when `n = 1`).
- All arithmetic is WIDTH bits. No intermediate exceeds WIDTH, since `modmult` reduces every step.

## Timing

**Reset values**
- Outputs: `result = 0`, `done = 0`, `busy = 0`.
- State: `IDLE`.
- All internal registers cleared.

**Reset mid-operation**
- Both `modexp_ctrl` and `modmult` return to idle immediately.
- No `done` pulse is produced.

**`modmult` latency**
- `mm_done` arrives k+2 cycles after the `mm_go` cycle, where k is the bit length of `mm_b`.

**Overall latency**
- Default build: WIDTH × (MUL call + SQR call + 2 GO cycles) + 1 (`FINISH`).
- Both calls use `sq_r` as `b`, so the schedule is independent of `exp`.
- `done` is registered-state decoded and has no combinational path from `go`.

## Configuration

`MODEXP_EARLY_EXIT_EN`
- **Undefined (default): fixed schedule.**
  - WIDTH iterations.
  - MUL is always issued, even when the exponent bit is 0.
  - SQR is always issued, including on the final bit.
- **Defined: short-circuit operation.**
  - In `MUL_GO`, if `e_r[0] = 0`, skip directly to `SQR_GO`.
  - In `MUL_WAIT`, if `(e_r >> 1) == 0`, go straight to `FINISH` and skip the final squaring.
  - In `IDLE`, if `exp == 0`, go to `FINISH` directly. `done` appears 2 cycles after `go`.
  - Results are identical to the default build; only timing changes.

## Structure

**Package `modexp_pkg`**
- `state_t` enum: `IDLE`, `MUL_GO`, `MUL_WAIT`, `SQR_GO`, `SQR_WAIT`, `FINISH`.
- Any shared localparams.

**Sub-module**
- Exactly one instance of the existing `modmult #(.WIDTH(WIDTH))`.
- Its ports are driven by the `mm_go`, `mm_a`, `mm_b`, `mm_n` signals.
- No other sub-modules.

## Test plan

Unless noted, each scenario runs in both macro configurations.

- WIDTH=16, base=4, exp=13, n=497, `go` pulse → exactly one `done` pulse with `result = 445`; `busy` low after it.
- base=2, exp=10, n=1000 → `result = 24`. base=3, exp=0, n=7 → `result = 1`. base=5, exp=3, n=1 → `result = 0`.
- Default build, n=497, base=4, exp=0x0001 vs exp=0xFFFF → identical `go`-to-`done` cycle counts.
- Start base=4, exp=13, n=497; pulse `go` with base=2, exp=10, n=1000 mid-run → ignored; `result = 445`.
- Assert `rst` during `SQR_WAIT` → `done`, `busy` and `result` read 0 next cycle; a fresh `go` (base=4, exp=13, n=497) completes with `result = 445`.
- `MODEXP_EARLY_EXIT_EN` defined, exp=0 → `done` 2 cycles after `go`. exp=1, base=9, n=7 → `result = 2`, with no SQR call issued.
